// File: rtl/addn_serial.sv
// Digit-serial adder: adds DIGIT bits per cycle, LSB digit first, with a ready/valid handshake.
// Define ADDN_SUB_EN to add the sub port and A - B - Cin subtraction.
module addn_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADDN_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (DIGIT <= 0) begin : g_bad_digit
      $error("addn_serial: DIGIT must be positive");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
      $error("addn_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_upd;
  logic             c_r;
  logic             sub_i;
  logic [31:0]      sh;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic             last;

`ifdef ADDN_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // Digit slice selected by the counter; the carry into the digit MSB feeds overflow detection.
  always_comb begin
    sh              = 32'(cnt) * 32'(DIGIT);
    a_dig           = DIGIT'(a_r >> sh);
    b_dig           = DIGIT'(b_r >> sh);
    {d_cout, d_sum} = digit_add(a_dig, b_dig, c_r);
    d_cmsb          = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ d_sum[DIGIT-1];
    acc_upd         = WIDTH'(d_sum) << sh;
    last            = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operands are captured already inverted for subtraction so RUN only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      c_r  <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= A;
            b_r <= B ^ {WIDTH{sub_i}};
            c_r <= Cin ^ sub_i;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc | acc_upd;
          c_r <= d_cout;
          if (last) begin
            sum  <= acc | acc_upd;
            cout <= d_cout;
            ovf  <= d_cout ^ d_cmsb;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addn_serial.sv
// Bench for addn_serial: a DIGIT=4 and a DIGIT=16 instance run in lockstep against an arithmetic model.
module tb_addn_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        sub;

  logic        in_ready,  out_valid,  cout,  ovf;
  logic [15:0] sum;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] sum1;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  logic [15:0] prev_sum;

  always #5 clk = ~clk;

  addn_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
`ifdef ADDN_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  addn_serial #(.WIDTH(16), .DIGIT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(A), .B(B), .Cin(Cin),
`ifdef ADDN_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic on the operands.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    int ua, ub, sa, sb, cc, r, sr;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    cc = int'(ci);
    if (s) begin
      r  = ua - ub - cc;
      sr = sa - sb - cc;
      co = (r >= 0);
    end else begin
      r  = ua + ub + cc;
      sr = sa + sb + cc;
      co = (r > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, r[15:0]};
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic s, input int hold);
    logic [17:0] e;
    logic        sx;
    int          lat, lat0, lat1;
`ifdef ADDN_SUB_EN
    sx = s;
`else
    sx = 1'b0;
`endif
    e = model(a, b, ci, sx);
    check("in_ready_idle", in_ready, 1);
    check("in_ready1_idle", in_ready1, 1);
    A = a; B = b; Cin = ci; sub = sx; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
    check("in_ready_busy", in_ready, 0);
    lat = 0; lat0 = -1; lat1 = -1;
    do begin
      if (lat == 2) check("sum_hold_run", sum, prev_sum);
      @(posedge clk); #1;
      lat++;
      if (out_valid  && lat0 < 0) lat0 = lat;
      if (out_valid1 && lat1 < 0) lat1 = lat;
    end while ((lat0 < 0 || lat1 < 0) && lat < 40);
    check("latency4", lat0, 4);
    check("latency16", lat1, 1);
    check("sum", sum, e[15:0]);
    check("cout", cout, e[16]);
    check("ovf", ovf, e[17]);
    check("sum1", sum1, e[15:0]);
    check("cout1", cout1, e[16]);
    check("ovf1", ovf1, e[17]);
    prev_sum = e[15:0];
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, e[15:0]);
      check("hold_cout", cout, e[16]);
      check("hold_in_ready", in_ready, 0);
      check("hold_valid1", out_valid1, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("sum_hold_idle", sum, e[15:0]);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0; prev_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 3);
`ifdef ADDN_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
`endif

    // Abort an operation while the narrow instance is on digit 2.
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    check("abort_out_valid1", out_valid1, 0);
    check("abort_sum1", sum1, 0);
    prev_sum = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    for (int n = 0; n < 12; n++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), (n % 4 == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
